// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and the baud increment used by both ends.
// The ParityBit state only exists when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        Idle,
        StartBit,
        DataBits,
`ifdef UART_TX_PARITY_EN
        ParityBit,
`endif
        StopBit,
        Complete
    } TxState;

    // Increment that makes the accumulator's top bit fire once per bit period, rounded to nearest.
    function automatic int unsigned count_inc(input int unsigned source_freq,
                                              input int unsigned baud,
                                              input int unsigned acc_width);
        logic [63:0] num;
        logic [63:0] den;
        num = (64'(baud) << (acc_width - 4)) + (64'(source_freq) >> 5);
        den = 64'(source_freq) >> 4;
        return 32'(num / den);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud accumulator: adds COUNT_INC every cycle; the top bit is the tick and clears the count.
// A synchronous clear restarts the bit period from zero.
module uart_baud_gen #(
    parameter int unsigned ACCUMULATOR_WIDTH = 16,
    parameter int unsigned COUNT_INC         = 151
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam logic [ACCUMULATOR_WIDTH:0] INC = (ACCUMULATOR_WIDTH + 1)'(COUNT_INC);

    logic [ACCUMULATOR_WIDTH:0] count_q;
    logic [ACCUMULATOR_WIDTH:0] count_d;

    assign tick = count_q[ACCUMULATOR_WIDTH];

    always_comb begin
        count_d = count_q + INC;
        if (clear || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, LSB first, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned SOURCE_FREQ       = 50000000,
    parameter int unsigned BAUD              = 115200,
    parameter int unsigned ACCUMULATOR_WIDTH = 16,
    parameter int unsigned STOP_BITS         = 1
) (
    input  logic       sourceClk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned COUNT_INC = count_inc(SOURCE_FREQ, BAUD, ACCUMULATOR_WIDTH);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    TxState     state_q,   state_d;
    logic [7:0] shift_q,   shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       tx_out_q,  tx_out_d;
    logic       tx_busy_q, tx_busy_d;
    logic       tx_done_q, tx_done_d;
`ifdef UART_TX_PARITY_EN
    logic       parity_q,  parity_d;
`endif
    logic       baud_clear;
    logic       baud_tick;

    uart_baud_gen #(
        .ACCUMULATOR_WIDTH(ACCUMULATOR_WIDTH),
        .COUNT_INC        (COUNT_INC)
    ) u_baud_gen (
        .clk  (sourceClk),
        .rst_n(reset),
        .clear(baud_clear),
        .tick (baud_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        tx_out_d   = tx_out_q;
        tx_busy_d  = tx_busy_q;
        tx_done_d  = 1'b0;
        baud_clear = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            Idle: begin
                if (tx_start) begin
                    state_d    = StartBit;
                    shift_d    = tx_byte;
                    bit_cnt_d  = 3'd0;
                    tx_busy_d  = 1'b1;
                    tx_out_d   = 1'b0;
                    baud_clear = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d   = ^tx_byte;
`endif
                end
            end
            StartBit: begin
                if (baud_tick) begin
                    state_d  = DataBits;
                    tx_out_d = shift_q[0];
                end
            end
            DataBits: begin
                if (baud_tick) begin
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d   = ParityBit;
                        tx_out_d  = parity_q;
`else
                        state_d   = StopBit;
                        tx_out_d  = 1'b1;
`endif
                    end else begin
                        // Next data bit is already sitting in shift_q[1].
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_out_d  = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ParityBit: begin
                if (baud_tick) begin
                    state_d  = StopBit;
                    tx_out_d = 1'b1;
                end
            end
`endif
            StopBit: begin
                if (baud_tick) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        state_d   = Complete;
                        tx_done_d = 1'b1;
                        tx_busy_d = 1'b0;
                        tx_out_d  = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            Complete: begin
                state_d = Idle;
            end
            default: begin
                state_d = Idle;
            end
        endcase
    end

    always_ff @(posedge sourceClk or negedge reset) begin
        if (!reset) begin
            state_q   <= Idle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_out_q  <= 1'b1;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_out_q  <= tx_out_d;
            tx_busy_q <= tx_busy_d;
            tx_done_q <= tx_done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign tx_out  = tx_out_q;
    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;

endmodule
